// File: rtl/rtc_scan_reader_if.sv
// rtl/rtc_scan_reader_if.sv - multiplexed address/data bus to the external RTC chip
interface rtc_scan_reader_if;
    logic [7:0] bus_i;   // data bus as read from the pad
    logic [7:0] bus_o;   // data bus value to drive
    logic       bus_oe;  // 1 = FPGA drives the bus
    logic       cs_n;    // chip select, active-low
    logic       rd_n;    // read strobe, active-low
    logic       wr_n;    // write strobe, active-low (address latch only)
    logic       a_d;     // 0 = address phase, 1 = data phase

    modport master (
        input  bus_i,
        output bus_o, bus_oe, cs_n, rd_n, wr_n, a_d
    );

    modport slave (
        output bus_i,
        input  bus_o, bus_oe, cs_n, rd_n, wr_n, a_d
    );
endinterface

// File: rtl/rtc_scan_reader.sv
// rtl/rtc_scan_reader.sv - scans RTC time/date/timer registers into a coherent BCD snapshot
module rtc_scan_reader #(
    parameter int TPH = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    rtc_scan_reader_if.master   bus,
    output logic                busy,
    output logic                done,
    output logic [7:0]          h_seg,
    output logic [7:0]          h_min,
    output logic [7:0]          h_hora,
    output logic [7:0]          date,
    output logic [7:0]          mes,
    output logic [7:0]          ano,
    output logic [7:0]          t_seg,
    output logic [7:0]          t_min,
    output logic [7:0]          t_hora
);

    localparam int              PW      = (TPH > 1) ? $clog2(TPH) : 1;
    localparam logic [PW-1:0]   PH_LAST = PW'(TPH - 1);
    localparam logic [3:0]      IDX_LAST = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_GAP1,
        S_DATA,
        S_GAP2,
        S_COMMIT
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [PW-1:0]  r_phase;
    logic [PW-1:0]  w_phase_nxt;
    logic [3:0]     r_idx;
    logic [3:0]     w_idx_nxt;
    logic           w_phase_last;

    logic [7:0]     r_shadow [0:8];

    // Registered copies of every output; next values come from the next state
    logic [7:0]     r_bus_o,  w_bus_o;
    logic           r_bus_oe, w_bus_oe;
    logic           r_cs_n,   w_cs_n;
    logic           r_rd_n,   w_rd_n;
    logic           r_wr_n,   w_wr_n;
    logic           r_a_d,    w_a_d;
    logic           r_busy,   w_busy;
    logic           r_done,   w_done;
    logic           w_capture;
    logic           w_commit;
    logic [7:0]     r_h_seg, r_h_min, r_h_hora, r_date, r_mes, r_ano;
    logic [7:0]     r_t_seg, r_t_min, r_t_hora;

    // RTC register address for each scan slot: clock/date block then timer block
    function automatic logic [7:0] addr_of(input logic [3:0] idx);
        logic [7:0] a;
        case (idx)
            4'd0:    a = 8'h21;
            4'd1:    a = 8'h22;
            4'd2:    a = 8'h23;
            4'd3:    a = 8'h24;
            4'd4:    a = 8'h25;
            4'd5:    a = 8'h26;
            4'd6:    a = 8'h41;
            4'd7:    a = 8'h42;
            4'd8:    a = 8'h43;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    assign w_phase_last = (r_phase == PH_LAST);

    // Next-state, phase/index and next-output decode
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_phase_nxt = '0;
        w_capture   = 1'b0;
        w_commit    = 1'b0;
        w_bus_o     = 8'h00;
        w_bus_oe    = 1'b0;
        w_cs_n      = 1'b1;
        w_rd_n      = 1'b1;
        w_wr_n      = 1'b1;
        w_a_d       = 1'b1;
        w_busy      = 1'b0;
        w_done      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ADDR;
                    w_idx_nxt   = 4'd0;
                end
            end
            S_ADDR: begin
                if (w_phase_last) w_state_nxt = S_GAP1;
            end
            S_GAP1: begin
                if (w_phase_last) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_phase_last) begin
                    w_state_nxt = S_GAP2;
                    w_capture   = 1'b1;
                end
            end
            S_GAP2: begin
                if (w_phase_last) begin
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = S_COMMIT;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = S_ADDR;
                        w_idx_nxt   = r_idx + 4'd1;
                    end
                end
            end
            S_COMMIT: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Phase counts only inside bus phases and restarts on every state change
        if (w_state_nxt == r_state &&
            (r_state == S_ADDR || r_state == S_GAP1 ||
             r_state == S_DATA || r_state == S_GAP2)) begin
            w_phase_nxt = r_phase + 1'b1;
        end

        // Bus pins for the cycle about to start, so the pins themselves are flops
        case (w_state_nxt)
            S_ADDR: begin
                w_a_d    = 1'b0;
                w_cs_n   = 1'b0;
                w_wr_n   = 1'b0;
                w_bus_oe = 1'b1;
                w_bus_o  = addr_of(w_idx_nxt);
            end
            S_GAP1: begin
                w_a_d    = 1'b0;
                w_bus_oe = 1'b1;
                w_bus_o  = addr_of(w_idx_nxt);
            end
            S_DATA: begin
                w_cs_n   = 1'b0;
                w_rd_n   = 1'b0;
            end
            S_COMMIT: begin
                w_done   = 1'b1;
            end
            default: ;
        endcase

        w_busy = (w_state_nxt != S_IDLE);
    end

    // State, counters, registered pins and the shadow/snapshot registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_phase  <= '0;
            r_idx    <= 4'd0;
            r_bus_o  <= 8'h00;
            r_bus_oe <= 1'b0;
            r_cs_n   <= 1'b1;
            r_rd_n   <= 1'b1;
            r_wr_n   <= 1'b1;
            r_a_d    <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            for (int i = 0; i < 9; i++) r_shadow[i] <= 8'h00;
            r_h_seg  <= 8'h00;
            r_h_min  <= 8'h00;
            r_h_hora <= 8'h00;
            r_date   <= 8'h00;
            r_mes    <= 8'h00;
            r_ano    <= 8'h00;
            r_t_seg  <= 8'h00;
            r_t_min  <= 8'h00;
            r_t_hora <= 8'h00;
        end else begin
            r_state  <= w_state_nxt;
            r_phase  <= w_phase_nxt;
            r_idx    <= w_idx_nxt;
            r_bus_o  <= w_bus_o;
            r_bus_oe <= w_bus_oe;
            r_cs_n   <= w_cs_n;
            r_rd_n   <= w_rd_n;
            r_wr_n   <= w_wr_n;
            r_a_d    <= w_a_d;
            r_busy   <= w_busy;
            r_done   <= w_done;
            if (w_capture) r_shadow[r_idx] <= bus.bus_i;
            // Snapshot moves as a whole so the display never sees a torn read
            if (w_commit) begin
                r_h_seg  <= r_shadow[0];
                r_h_min  <= r_shadow[1];
                r_h_hora <= r_shadow[2];
                r_date   <= r_shadow[3];
                r_mes    <= r_shadow[4];
                r_ano    <= r_shadow[5];
                r_t_seg  <= r_shadow[6];
                r_t_min  <= r_shadow[7];
                r_t_hora <= r_shadow[8];
            end
        end
    end

    assign bus.bus_o  = r_bus_o;
    assign bus.bus_oe = r_bus_oe;
    assign bus.cs_n   = r_cs_n;
    assign bus.rd_n   = r_rd_n;
    assign bus.wr_n   = r_wr_n;
    assign bus.a_d    = r_a_d;
    assign busy       = r_busy;
    assign done       = r_done;
    assign h_seg      = r_h_seg;
    assign h_min      = r_h_min;
    assign h_hora     = r_h_hora;
    assign date       = r_date;
    assign mes        = r_mes;
    assign ano        = r_ano;
    assign t_seg      = r_t_seg;
    assign t_min      = r_t_min;
    assign t_hora     = r_t_hora;

endmodule

// File: tb/tb_rtc_scan_reader.sv
// tb/tb_rtc_scan_reader.sv - scoreboard bench for rtc_scan_reader with a behavioural RTC model
module tb_rtc_scan_reader;

    localparam int TPH      = 4;
    localparam int DONE_LAT = 1 + 36 * TPH;   // 145
    localparam int PERIOD   = 36 * TPH + 2;   // 146

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic busy, done;
    logic [7:0] h_seg, h_min, h_hora, date, mes, ano, t_seg, t_min, t_hora;

    rtc_scan_reader_if bus_if ();

    rtc_scan_reader #(.TPH(TPH)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .bus    (bus_if),
        .busy   (busy),
        .done   (done),
        .h_seg  (h_seg),
        .h_min  (h_min),
        .h_hora (h_hora),
        .date   (date),
        .mes    (mes),
        .ano    (ano),
        .t_seg  (t_seg),
        .t_min  (t_min),
        .t_hora (t_hora)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RTC model: latch address on the write strobe, drive data while read strobe is low
    logic [7:0] mem [0:255];
    logic [7:0] lat_addr = 8'h00;
    always @(posedge clk)
        if (!bus_if.cs_n && !bus_if.wr_n && !bus_if.a_d) lat_addr <= bus_if.bus_o;
    assign bus_if.bus_i = (!bus_if.cs_n && !bus_if.rd_n) ? mem[lat_addr] : 8'hFF;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [71:0] snap;
        int          cyc;
    } exp_t;

    exp_t       q_exp [$];
    logic [7:0] q_addr [$];

    function automatic logic [71:0] snap_now();
        return {h_seg, h_min, h_hora, date, mes, ano, t_seg, t_min, t_hora};
    endfunction

    // Monitor: every done pulse pops one expected snapshot
    always @(negedge clk) begin
        if (done) begin
            if (q_exp.size() == 0) begin
                chk("unexpected_done", 72'd1, 72'd0);
            end else begin
                exp_t e;
                e = q_exp.pop_front();
                chk("done_cycle", 72'(cyc), 72'(e.cyc));
                chk("snapshot", snap_now(), e.snap);
            end
        end
    end

    // Monitor: first cycle of each address phase pops one expected address
    logic prev_wr_n = 1'b1;
    always @(negedge clk) begin
        if (!bus_if.wr_n && prev_wr_n) begin
            if (q_addr.size() == 0) chk("unexpected_addr", 72'(bus_if.bus_o), 72'hFFF);
            else chk("bus_addr", 72'(bus_if.bus_o), 72'(q_addr.pop_front()));
        end
        prev_wr_n = bus_if.wr_n;
    end

    // Monitor: strobe widths, gap widths and pin invariants
    int   wr_run = 0, rd_run = 0, cs_hi_run = 0;
    logic wr_ok = 1'b1, rd_ok = 1'b1;
    logic pin_bad = 1'b0;
    always @(negedge clk) begin
        if (!bus_if.bus_oe && bus_if.bus_o != 8'h00) pin_bad = 1'b1;
        if (bus_if.bus_oe && !bus_if.rd_n) pin_bad = 1'b1;
        if (!reset) begin
            wr_run = 0; rd_run = 0; cs_hi_run = 0;
            wr_ok = 1'b1; rd_ok = 1'b1;
        end else begin
            if (!bus_if.wr_n) begin
                wr_run++;
                wr_ok &= (!bus_if.a_d && bus_if.bus_oe);
            end else if (wr_run > 0) begin
                chk("wr_n_width", 72'(wr_run), 72'(TPH));
                chk("wr_phase_pins", 72'(wr_ok), 72'd1);
                wr_run = 0; wr_ok = 1'b1;
            end
            if (!bus_if.rd_n) begin
                rd_run++;
                rd_ok &= (bus_if.a_d && !bus_if.bus_oe);
            end else if (rd_run > 0) begin
                chk("rd_n_width", 72'(rd_run), 72'(TPH));
                chk("rd_phase_pins", 72'(rd_ok), 72'd1);
                rd_run = 0; rd_ok = 1'b1;
            end
            if (busy && bus_if.cs_n) begin
                cs_hi_run++;
            end else begin
                if (busy && !bus_if.cs_n && cs_hi_run > 0)
                    chk("gap_width", 72'(cs_hi_run), 72'(TPH));
                cs_hi_run = 0;
            end
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_scan(input logic [71:0] snap, input int n);
        exp_t e;
        e.snap = snap;
        e.cyc  = n + DONE_LAT;
        q_exp.push_back(e);
        q_addr.push_back(8'h21); q_addr.push_back(8'h22); q_addr.push_back(8'h23);
        q_addr.push_back(8'h24); q_addr.push_back(8'h25); q_addr.push_back(8'h26);
        q_addr.push_back(8'h41); q_addr.push_back(8'h42); q_addr.push_back(8'h43);
    endtask

    // Pulses start for one cycle; returns N, the cycle start was sampled in
    task automatic pulse_start(input logic [71:0] snap, output int n);
        n = cyc;
        push_scan(snap, n);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    function automatic logic [71:0] idle_pins();
        return 72'({busy, done, bus_if.cs_n, bus_if.rd_n, bus_if.wr_n,
                    bus_if.a_d, bus_if.bus_oe, bus_if.bus_o});
    endfunction

    localparam logic [71:0] IDLE_PINS = 72'({1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00});

    localparam logic [71:0] SNAP_BASIC = 72'h31_32_33_34_35_36_51_52_53;
    localparam logic [71:0] SNAP_COHER = 72'h31_59_33_34_35_36_51_52_53;
    localparam logic [71:0] SNAP_ZMIN  = 72'h31_00_33_34_35_36_51_52_53;
    localparam logic [71:0] SNAP_B2B   = 72'h31_00_33_34_35_36_51_52_99;

    initial begin
        int n;
        for (int a = 0; a < 256; a++) mem[a] = 8'(a + 8'h10);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pins", idle_pins(), IDLE_PINS);
        chk("reset_snapshot", snap_now(), 72'd0);
        reset = 1'b1;
        wait_until(cyc + 5);
        chk("idle_after_reset", idle_pins(), IDLE_PINS);

        // Basic scan, phase timing checked by the monitors
        pulse_start(SNAP_BASIC, n);
        wait_until(n + DONE_LAT + 5);

        // Coherence: h_min source changes after index 1 has been captured
        mem[8'h22] = 8'h59;
        pulse_start(SNAP_COHER, n);
        wait_until(n + 7 * TPH + 2);
        mem[8'h22] = 8'h00;
        wait_until(n + DONE_LAT - 1);
        chk("hold_old_snapshot", 72'(h_min), 72'h32);
        wait_until(n + DONE_LAT + 5);

        // Ignored start during DATA of index 3
        pulse_start(SNAP_ZMIN, n);
        wait_until(n + (4 * 3 + 2) * TPH + 2);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_until(n + DONE_LAT + 20);
        chk("no_second_scan", idle_pins(), IDLE_PINS);

        // Reset mid-scan during DATA of index 5
        pulse_start(SNAP_ZMIN, n);
        wait_until(n + (4 * 5 + 2) * TPH + 2);
        void'(q_exp.pop_back());
        reset = 1'b0;
        @(posedge clk);
        #1;
        q_addr.delete();
        chk("midscan_reset_pins", idle_pins(), IDLE_PINS);
        chk("midscan_reset_snapshot", snap_now(), 72'd0);
        reset = 1'b1;
        wait_until(cyc + 20);
        chk("stay_idle_after_reset", idle_pins(), IDLE_PINS);

        // Back-to-back scans with start held high
        mem[8'h43] = 8'h99;
        n = cyc;
        push_scan(SNAP_B2B, n);
        push_scan(SNAP_B2B, n + PERIOD);
        start = 1'b1;
        wait_until(n + 200);
        start = 1'b0;
        wait_until(n + PERIOD + DONE_LAT + 10);

        chk("scoreboard_drained", 72'(q_exp.size()), 72'd0);
        chk("addr_queue_drained", 72'(q_addr.size()), 72'd0);
        chk("pin_invariants", 72'(pin_bad), 72'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
